// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared word-size constants and helpers for the fetch front end
package cpu_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instructions are word aligned; the low address bits carry no meaning.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush, head look-ahead and occupancy count
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush discards all entries and wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates every reader.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));
  assert property (@(posedge clk) disable iff (rst) !(pop && empty && !flush));

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage: PC, credit-limited issue, response queue, redirect
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              req_valid_o,
  output logic [WORD_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              rsp_valid_i,
  input  logic [WORD_W-1:0] rsp_data_i,
  output logic              instr_valid_o,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pc_o,
  output logic [WORD_W-1:0] pc4_o,
  input  logic              instr_ready_i,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] redirect_pc_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0]   fetch_pc;
  logic [CW-1:0]       occ;
  logic [CW-1:0]       out_cnt;
  logic [CW-1:0]       drop_cnt;
  logic [CW:0]         credit_used;
  logic [WORD_W-1:0]   tag_pc;
  logic [2*WORD_W-1:0] q_head;
  logic                q_full, q_empty, tag_full, tag_empty;
  logic                accept, drop_now, q_push, q_pop;

  // Queued entries plus in-flight requests may never exceed DEPTH, so a
  // response always has a slot waiting for it.
  assign credit_used = {1'b0, occ} + {1'b0, out_cnt};
  assign req_valid_o = !rst_i && !redirect_i && (credit_used < (CW+1)'(DEPTH));
  assign req_addr_o  = fetch_pc;
  assign accept      = req_valid_o && req_ready_i;

  // Responses to requests issued before a redirect are thrown away.
  assign drop_now = rsp_valid_i && (drop_cnt != '0);
  assign q_push   = rsp_valid_i && !drop_now && !redirect_i;
  assign q_pop    = instr_valid_o && instr_ready_i && !redirect_i;

  assign instr_valid_o = !q_empty;
  assign pc_o          = instr_valid_o ? q_head[2*WORD_W-1:WORD_W] : '0;
  assign instr_o       = instr_valid_o ? q_head[WORD_W-1:0] : '0;
  assign pc4_o         = instr_valid_o ? q_head[2*WORD_W-1:WORD_W] + WORD_W'(INSTR_BYTES) : '0;

  // Issued addresses in order; every response pops one, so its depth is the in-flight count.
  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_tag_q (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_valid_i),
    .flush     (1'b0),
    .head      (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (out_cnt)
  );

  // Returned instructions with their PC, waiting for decode.
  sync_fifo #(.WIDTH(2*WORD_W), .DEPTH(DEPTH)) u_instr_q (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (q_push),
    .push_data ({tag_pc, rsp_data_i}),
    .pop       (q_pop),
    .flush     (redirect_i),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (occ)
  );

  // Fetch PC: a redirect restarts at the aligned target, an accepted request advances a word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            fetch_pc <= RESET_PC;
    else if (redirect_i)  fetch_pc <= word_align(redirect_pc_i);
    else if (accept)      fetch_pc <= fetch_pc + WORD_W'(INSTR_BYTES);
  end

  // Drop counter: on redirect every survivor in flight becomes stale; a response
  // arriving in the redirect cycle itself is already discarded by the flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           drop_cnt <= '0;
    else if (redirect_i) drop_cnt <= out_cnt - CW'(rsp_valid_i);
    else if (drop_now)   drop_cnt <= drop_cnt - 1'b1;
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !(rsp_valid_i && tag_empty));
  assert property (@(posedge clk_i) disable iff (rst_i) !(accept && tag_full));
  assert property (@(posedge clk_i) disable iff (rst_i) !(q_push && q_full));
  assert property (@(posedge clk_i) disable iff (rst_i) drop_cnt <= out_cnt);

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with a queue-level reference model
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o, pc_o, pc4_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_o   (req_valid_o),
    .req_addr_o    (req_addr_o),
    .req_ready_i   (req_ready_i),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_data_i    (rsp_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc4_o         (pc4_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] pc; bit stale; }        flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  typedef struct { logic [31:0] addr; int due; }         mreq_t;

  entry_t      exp_q[$];
  flight_t     infl[$];
  mreq_t       mem_q[$];
  logic [31:0] m_pc;

  int cyc, lat_min, lat_max, rsp_prob;
  int checks, passed, fails;
  int first_acc, first_iv, ndel, nacc, exp_drop;
  bit got, found;
  bit obs_acc, obs_iv, obs_cons;
  logic [31:0] obs_addr, obs_pc, resume_addr, first_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit rsp_due();
    return (mem_q.size() > 0) && (mem_q[0].due <= cyc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (failure #%0d)", tag, obs, expv, fails);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_valid"},   req_valid_o,   32'd0);
    chk({tag, "_instr_valid"}, instr_valid_o, 32'd0);
    chk({tag, "_instr"},       instr_o,       32'd0);
    chk({tag, "_pc"},          pc_o,          32'd0);
    chk({tag, "_pc4"},         pc4_o,         32'd0);
  endtask

  // Asserts reset asynchronously, checks outputs before any clock edge, then
  // releases it at a falling edge. The memory is reset alongside.
  task automatic do_reset();
    rst_i = 1'b1;
    req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = '0;
    instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    #1;
    chk_idle_outputs("reset");
    exp_q.delete(); infl.delete(); mem_q.delete();
    m_pc = RESET_PC;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input bit rdy, input bit irdy, input bit redir, input logic [31:0] tgt);
    bit          exp_rv, m_acc, m_cons, rsp;
    logic [31:0] data;
    flight_t     f;
    req_ready_i   = rdy;
    instr_ready_i = irdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    rsp  = rsp_due() && ($urandom_range(99) < rsp_prob);
    data = $urandom;
    if (rsp) data = instr_of(mem_q[0].addr);
    rsp_valid_i = rsp;
    rsp_data_i  = data;
    #1;
    exp_rv = !redir && ((exp_q.size() + infl.size()) < DEPTH);
    chk("req_valid",   req_valid_o,   exp_rv);
    chk("req_addr",    req_addr_o,    m_pc);
    chk("instr_valid", instr_valid_o, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("instr", instr_o, exp_q[0].instr);
      chk("pc",    pc_o,    exp_q[0].pc);
      chk("pc4",   pc4_o,   exp_q[0].pc + 32'd4);
    end else begin
      chk("instr_idle", instr_o, 32'd0);
      chk("pc_idle",    pc_o,    32'd0);
    end
    obs_acc  = req_valid_o && rdy;
    obs_addr = req_addr_o;
    obs_iv   = instr_valid_o;
    obs_cons = instr_valid_o && irdy;
    obs_pc   = pc_o;
    m_acc    = exp_rv && rdy;
    m_cons   = (exp_q.size() > 0) && irdy;
    @(posedge clk_i);
    if (rsp) void'(mem_q.pop_front());
    if (obs_acc) mem_q.push_back('{obs_addr, cyc + int'($urandom_range(lat_max, lat_min))});
    if (redir) begin
      exp_q.delete();
      if (rsp && infl.size() > 0) void'(infl.pop_front());
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_pc = {tgt[31:2], 2'b00};
    end else begin
      if (m_cons) void'(exp_q.pop_front());
      if (rsp && infl.size() > 0) begin
        f = infl.pop_front();
        if (!f.stale) exp_q.push_back('{f.pc, data});
      end
      if (m_acc) begin
        infl.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk_i);
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0; passed = 0; fails = 0; cyc = 0;
    lat_min = 1; lat_max = 1; rsp_prob = 100;

    // Streaming with a zero-wait memory and an always-ready decoder.
    do_reset();
    first_acc = -1; first_iv = -1; ndel = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      if (obs_acc && first_acc < 0) first_acc = i;
      if (obs_iv && first_iv < 0)   first_iv = i;
      if (obs_cons) ndel++;
    end
    chk("first_instr_latency", first_iv - first_acc, 32'd2);
    chk("stream_rate", ndel, 32'd10);

    // Decoder stalled: credit limits issue to DEPTH, then resumes in order.
    do_reset();
    nacc = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      if (obs_acc) nacc++;
    end
    chk("credit_issued", nacc, DEPTH);
    chk("credit_stall", req_valid_o, 32'd0);
    got = 1'b0; resume_addr = '1;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      if (obs_acc) begin got = 1'b1; resume_addr = obs_addr; end
    end
    chk("resume_addr", resume_addr, 32'h10);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect with two requests outstanding on a 3-cycle memory.
    do_reset();
    lat_min = 3; lat_max = 3;
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("outstanding_two", dut.out_cnt, 32'd2);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    chk("redirect_drop_two", dut.drop_cnt, 32'd2);
    got = 1'b0; first_pc = '1;
    for (int i = 0; i < 30 && !got; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      if (obs_iv) begin got = 1'b1; first_pc = obs_pc; end
    end
    chk("first_pc_after_redirect", first_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a consume.
    do_reset();
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (i > 3 && rsp_due() && exp_q.size() > 0) found = 1'b1;
      else cycle(1'b1, 1'b1, 1'b0, 32'd0);
    end
    chk("redirect_setup_found", found, 32'd1);
    if (found) begin
      exp_drop = infl.size() - 1;
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0040);
      chk("redirect_queue_empty", instr_valid_o, 32'd0);
      chk("redirect_drop_cnt", dut.drop_cnt, exp_drop);
      chk("redirect_out_cnt", dut.out_cnt, exp_drop);
    end
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Memory back-pressure: request held stable, in-flight count frozen.
    do_reset();
    lat_min = 1; lat_max = 1; rsp_prob = 0;
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("stall_addr_held", req_addr_o, 32'h8);
      chk("stall_valid_held", req_valid_o, 32'd1);
      chk("stall_out_cnt", dut.out_cnt, 32'd2);
    end
    rsp_prob = 100;
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("stall_release_acc", obs_acc, 32'd1);
    chk("stall_release_addr", obs_addr, 32'h8);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Asynchronous reset mid-stream with three entries queued.
    do_reset();
    for (int i = 0; i < 20 && exp_q.size() < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("three_queued", exp_q.size(), 32'd3);
    chk("three_queued_valid", instr_valid_o, 32'd1);
    #2;
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("restart_acc", obs_acc, 32'd1);
    chk("restart_addr", obs_addr, RESET_PC);

    // Randomised traffic, including redirects near the top of the address space.
    lat_min = 1; lat_max = 4; rsp_prob = 70;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 75, $urandom_range(99) < 70, $urandom_range(99) < 3,
            ($urandom_range(3) == 0) ? 32'hFFFF_FFF5 : $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
